// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: instruction word layout, opcodes and
// the sequencer FSM encoding.
package seq_pkg;

  localparam int unsigned INSTR_W = 14;

  localparam int unsigned F_MSB    = 13;
  localparam int unsigned F_LSB    = 12;
  localparam int unsigned RX_MSB   = 11;
  localparam int unsigned RX_LSB   = 10;
  localparam int unsigned RY_MSB   = 9;
  localparam int unsigned RY_LSB   = 8;
  localparam int unsigned DATA_MSB = 7;
  localparam int unsigned DATA_LSB = 0;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StWait  = 2'b10
  } seq_state_e;

endpackage

// File: rtl/instr_fifo.sv
// DEPTH x INSTR_W synchronous FIFO holding queued instructions; DEPTH must be a power of two
// and at least 2. Pointers wrap naturally; occupancy is kept in its own counter.
module instr_fifo
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic                    push_i,
  input  logic [INSTR_W-1:0]      wdata_i,
  input  logic                    pop_i,
  output logic [INSTR_W-1:0]      head_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]    head_q, head_d;
  logic [PtrW-1:0]    tail_q, tail_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_ok) tail_d = tail_q + 1'b1;
    if (pop_ok)  head_d = head_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok && !Reset) mem_q[tail_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Queues host instructions and hands them one at a time to the processor via the w/Tstep0/Done
// handshake. Define SEQ_WATCHDOG_EN to abort instructions stuck in WAIT for WD_LIMIT cycles.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned WD_LIMIT = 15
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               InValid,
  output logic               InReady,
  input  logic [INSTR_W-1:0] InInstr,
  input  logic               Tstep0,
  input  logic               Done,
  output logic               w,
  output logic [1:0]         F,
  output logic [1:0]         Rx,
  output logic [1:0]         Ry,
  output logic [7:0]         Data,
  output logic               Busy,
  output logic [7:0]         Retired,
  output logic               Err
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  seq_state_e         state_q, state_d;
  logic [7:0]         retired_q, retired_d;
  logic [INSTR_W-1:0] fifo_head;
  logic [CntW-1:0]    fifo_count;
  logic               fifo_full, fifo_empty;
  logic               push_ok, pop;
  logic               more_after_pop;

  instr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .Reset   (Reset),
    .push_i  (InValid),
    .wdata_i (InInstr),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign InReady = ~fifo_full;
  assign push_ok = InValid & ~fifo_full;
  // A same-cycle push keeps the queue occupied even when the head is the last entry.
  assign more_after_pop = push_ok | (fifo_count > CntW'(1));

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(WD_LIMIT + 1);
  logic [WdW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
  assign Err = err_q;
`else
  logic [31:0] unused_wd_limit;
  assign unused_wd_limit = WD_LIMIT;
  assign Err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    pop       = 1'b0;
`ifdef SEQ_WATCHDOG_EN
    wd_d      = wd_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StIssue;
      end
      StIssue: begin
        if (Tstep0) begin
          state_d = StWait;
`ifdef SEQ_WATCHDOG_EN
          wd_d    = '0;
`endif
        end
      end
      StWait: begin
        if (Done) begin
          pop       = 1'b1;
          retired_d = retired_q + 8'd1;
          state_d   = more_after_pop ? StIssue : StIdle;
        end
`ifdef SEQ_WATCHDOG_EN
        else if (wd_q == WdW'(WD_LIMIT - 1)) begin
          pop     = 1'b1;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      retired_q <= '0;
`ifdef SEQ_WATCHDOG_EN
      wd_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
`ifdef SEQ_WATCHDOG_EN
      wd_q      <= wd_d;
      err_q     <= err_d;
`endif
    end
  end

  assign w       = (state_q == StIssue);
  assign Busy    = ~fifo_empty | (state_q != StIdle);
  assign Retired = retired_q;

  // Fields follow the head entry in ISSUE and WAIT and read as zero in IDLE.
  always_comb begin
    F    = '0;
    Rx   = '0;
    Ry   = '0;
    Data = '0;
    if (state_q != StIdle) begin
      F    = fifo_head[F_MSB:F_LSB];
      Rx   = fifo_head[RX_MSB:RX_LSB];
      Ry   = fifo_head[RY_MSB:RY_LSB];
      Data = fifo_head[DATA_MSB:DATA_LSB];
    end
  end

endmodule
